// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared types and default sizing for the PWM ramp sequencer and its timebase.
// The defaults must track the pwm datapath: PERIOD_CYCLES == 2**WIDTH.
package pwm_ramp_ctrl_pkg;
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    localparam int DEF_WIDTH         = 9;
    localparam int DEF_PERIOD_CYCLES = 512;
    localparam int DEF_HOLD_PERIODS  = 1;
    localparam int HOLD_W            = 8;
endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM period timebase.
// period_start is registered and marks the first clock of every period after the first wrap.
module pwm_period_timer
    import pwm_ramp_ctrl_pkg::*;
#(
    parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
    localparam int CW = $clog2(PERIOD_CYCLES)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] count,
    output logic          period_start
);
    logic last;

    assign last = (count == CW'(PERIOD_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= '0;
            period_start <= 1'b0;
        end else begin
            count        <= last ? '0 : count + CW'(1);
            period_start <= last;
        end
    end
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramp sequencer for the pwm duty input: moves value toward a commanded target in
// bounded steps, applied only on the edge that wraps the period counter.
module pwm_ramp_ctrl
    import pwm_ramp_ctrl_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
    parameter int HOLD_PERIODS  = DEF_HOLD_PERIODS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic [3:0]       cmd_step,
    input  logic             stop,
    output logic [WIDTH-1:0] value,
    output logic             period_start,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(PERIOD_CYCLES);

    state_t              state, state_nx;
    logic [WIDTH-1:0]    tgt_q, tgt_nx, value_nx;
    logic [3:0]          step_q, step_nx;
    logic [HOLD_W-1:0]   hold_cnt, hold_nx;
    logic                done_nx;
    logic [CW-1:0]       period_cnt;
    logic                boundary;
    logic                up;
    logic [WIDTH:0]      diff;

    pwm_period_timer #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_timer (
        .clk          (clk),
        .rst          (rst),
        .count        (period_cnt),
        .period_start (period_start)
    );

    // The wrapping edge is the one that makes the next period start.
    assign boundary  = (period_cnt == CW'(PERIOD_CYCLES - 1));
    assign busy      = (state == ST_RAMP);
    assign cmd_ready = (state == ST_IDLE) && !stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            value    <= '0;
            tgt_q    <= '0;
            step_q   <= '0;
            hold_cnt <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            value    <= value_nx;
            tgt_q    <= tgt_nx;
            step_q   <= step_nx;
            hold_cnt <= hold_nx;
            done     <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        value_nx = value;
        tgt_nx   = tgt_q;
        step_nx  = step_q;
        hold_nx  = hold_cnt;
        done_nx  = 1'b0;
        up       = (tgt_q > value);
        diff     = up ? ({1'b0, tgt_q} - {1'b0, value}) : ({1'b0, value} - {1'b0, tgt_q});

        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    tgt_nx  = cmd_target;
                    step_nx = cmd_step;
                    hold_nx = '0;
                    if (cmd_target == value) done_nx  = 1'b1;
                    else                     state_nx = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (stop) begin
                    state_nx = ST_IDLE;
                end else if (boundary) begin
                    if (hold_cnt == HOLD_W'(HOLD_PERIODS - 1)) begin
                        hold_nx = '0;
                        // Landing exactly on target avoids overshoot and wrap at both rails.
                        if (step_q == 4'd0 || diff <= (WIDTH + 1)'(step_q)) begin
                            value_nx = tgt_q;
                            state_nx = ST_IDLE;
                            done_nx  = 1'b1;
                        end else if (up) begin
                            value_nx = value + WIDTH'(step_q);
                        end else begin
                            value_nx = value - WIDTH'(step_q);
                        end
                    end else begin
                        hold_nx = hold_cnt + HOLD_W'(1);
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end
endmodule
